// File: rtl/pipe_mult.sv
// Purpose: pipelined WIDTH x WIDTH multiplier. It returns the low WIDTH bits of A*B and, with PIPE_MULT_FULLPROD_EN, the upper WIDTH bits.
// Latency: STAGES cycles from the launch edge to done_o. Throughput is one launch per cycle.
// Backpressure: none. A result shows for one done_o cycle, and product_o then holds it until the next completion.
module pipe_mult #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] multiplier_i,
  input  logic [WIDTH-1:0] multicand_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] product_o,
`ifdef PIPE_MULT_FULLPROD_EN
  output logic [WIDTH-1:0] product_hi_o,
`endif
  output logic             done_o
);

  localparam int CHUNK = WIDTH / STAGES;
`ifdef PIPE_MULT_FULLPROD_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  genvar s;
  for (s = 0; s < STAGES; s++) begin : g_stage
    // Each stage forwards only the multiplier bits that later stages still need.
    localparam int AW = WIDTH - s * CHUNK;

    logic             vld_in;
    logic [AW-1:0]    a_in;
    logic [WIDTH-1:0] b_in;
    logic [PW-1:0]    sum_in;
    logic [PW-1:0]    pp;

    logic             vld_q;
    logic [PW-1:0]    sum_q;

    if (s == 0) begin : g_first
      assign vld_in = start_i;
      assign a_in   = multiplier_i;
      assign b_in   = multicand_i;
      assign sum_in = '0;
    end else begin : g_next
      assign vld_in = g_stage[s-1].vld_q;
      assign a_in   = g_stage[s-1].g_fwd.a_q;
      assign b_in   = g_stage[s-1].g_fwd.b_q;
      assign sum_in = g_stage[s-1].sum_q;
    end

    assign pp = (PW'(b_in) * PW'(a_in[CHUNK-1:0])) << (s * CHUNK);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= 1'b0;
        sum_q <= '0;
      end else begin
        vld_q <= vld_in;
        sum_q <= sum_in + pp;
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      logic [AW-CHUNK-1:0] a_q;
      logic [WIDTH-1:0]    b_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_in[AW-1:CHUNK];
          b_q <= b_in;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_o    <= 1'b0;
      product_o <= '0;
`ifdef PIPE_MULT_FULLPROD_EN
      product_hi_o <= '0;
`endif
    end else begin
      done_o <= g_stage[STAGES-1].vld_q;
      if (g_stage[STAGES-1].vld_q) begin
        product_o <= g_stage[STAGES-1].sum_q[WIDTH-1:0];
`ifdef PIPE_MULT_FULLPROD_EN
        product_hi_o <= g_stage[STAGES-1].sum_q[PW-1:WIDTH];
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipe_mult.sv
// Bench for pipe_mult. A queue model tracks when each launch is due, its full product, and the held output value.
module tb_pipe_mult;

  localparam int WIDTH  = 32;
  localparam int STAGES = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] mplier = '0;
  logic [WIDTH-1:0] mcand = '0;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] product_hi;
  logic             done;

  pipe_mult #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .multiplier_i (mplier),
    .multicand_i  (mcand),
    .start_i      (start),
    .product_o    (product),
`ifdef PIPE_MULT_FULLPROD_EN
    .product_hi_o (product_hi),
`endif
    .done_o       (done)
  );

`ifndef PIPE_MULT_FULLPROD_EN
  assign product_hi = '0;
`endif

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct packed {
    int          due;
    logic [63:0] p;
  } exp_t;

  exp_t             q[$];
  logic             exp_done = 1'b0;
  logic [WIDTH-1:0] exp_prod = '0;
  logic [WIDTH-1:0] exp_hi = '0;
  int               vectors = 0;
  int               errors = 0;

  // The task drives one edge and lands on the following negedge. The model then yields what the outputs should show.
  task automatic cycle(input logic st, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    start  = st;
    mplier = a;
    mcand  = b;
    if (st && !rst) begin
      e.due = edges + 1 + STAGES;
      e.p   = 64'(a) * 64'(b);
      q.push_back(e);
    end
    @(negedge clk);
    exp_done = 1'b0;
    if (rst) begin
      q.delete();
      exp_prod = '0;
      exp_hi   = '0;
    end else if (q.size() > 0 && q[0].due == edges) begin
      e        = q.pop_front();
      exp_done = 1'b1;
      exp_prod = e.p[31:0];
      exp_hi   = e.p[63:32];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b1, 32'd9, 32'd9);
    cycle(1'b1, 32'd4, 32'd4);
    vectors++;
    if (done !== 1'b0 || product !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: done=%0b product=%h, expected done=0 product=0", done, product);
    end
    rst = 1'b0;
    for (int i = 0; i < STAGES + 4; i++) begin
      cycle(1'b0, '0, '0);
      vectors++;
      if (done !== 1'b0 || product !== 32'h0) begin
        errors++;
        $display("FAIL reset_discard: cyc %0d done=%0b product=%h, expected done=0 product=0", i, done, product);
      end
    end
  endtask

  task automatic test_directed(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] want, input logic [WIDTH-1:0] want_hi);
    int launch;
    int seen;
    launch = edges + 1;
    seen   = 0;
    cycle(1'b1, a, b);
    for (int i = 0; i < STAGES + 4; i++) begin
      vectors++;
      if (done !== exp_done || product !== exp_prod) begin
        errors++;
        $display("FAIL %s_model: done=%0b product=%h, expected done=%0b product=%h", name, done, product, exp_done, exp_prod);
      end
      if (done === 1'b1) begin
        seen++;
        vectors++;
        if (edges - launch != STAGES || product !== want) begin
          errors++;
          $display("FAIL %s: latency=%0d product=%h, expected latency=%0d product=%h", name, edges - launch, product, STAGES, want);
        end
`ifdef PIPE_MULT_FULLPROD_EN
        vectors++;
        if (product_hi !== want_hi) begin
          errors++;
          $display("FAIL %s_hi: product_hi=%h, expected %h", name, product_hi, want_hi);
        end
`endif
      end
      cycle(1'b0, $urandom, $urandom);
    end
    vectors++;
    if (seen != 1) begin
      errors++;
      $display("FAIL %s_pulses: got %0d done pulses, expected 1", name, seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] want[3];
    int               n;
    want[0] = 32'h6;
    want[1] = 32'h3F;
    want[2] = 32'h0;
    n = 0;
    cycle(1'b1, 32'd2, 32'd3);
    cycle(1'b1, 32'd7, 32'd9);
    cycle(1'b1, 32'h10000, 32'h10000);
    for (int i = 0; i < STAGES + 4; i++) begin
      cycle(1'b0, '0, '0);
      vectors++;
      if (done !== exp_done || product !== exp_prod) begin
        errors++;
        $display("FAIL b2b_model: done=%0b product=%h, expected done=%0b product=%h", done, product, exp_done, exp_prod);
      end
      if (done === 1'b1) begin
        vectors++;
        if (n > 2 || product !== want[n > 2 ? 2 : n]) begin
          errors++;
          $display("FAIL b2b_result: pulse %0d product=%h, expected %h", n, product, want[n > 2 ? 2 : n]);
        end
        n++;
      end
    end
    vectors++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d, expected 3", n);
    end
  endtask

  task automatic test_reset_abort();
    cycle(1'b1, 32'd5, 32'd5);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, '0);
    rst = 1'b1;
    cycle(1'b0, '0, '0);
    rst = 1'b0;
    for (int i = 0; i < STAGES + 6; i++) begin
      cycle(1'b0, '0, '0);
      vectors++;
      if (done !== 1'b0 || product !== 32'h0 || product_hi !== 32'h0) begin
        errors++;
        $display("FAIL reset_abort: cyc %0d done=%0b product=%h hi=%h, expected done=0 product=0 hi=0", i, done, product, product_hi);
      end
    end
  endtask

  task automatic test_random();
    int               launches;
    int               pulses;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    launches = 0;
    pulses   = 0;
    while (launches < 10000 || q.size() > 0) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = '1;
        1: b = 32'h8000_0000;
        default: ;
      endcase
      if (launches < 10000 && $urandom_range(0, 3) != 0) begin
        cycle(1'b1, a, b);
        launches++;
      end else begin
        cycle(1'b0, a, b);
      end
      if (done === 1'b1) pulses++;
      vectors++;
      if (done !== exp_done || product !== exp_prod) begin
        errors++;
        $display("FAIL random: edge %0d done=%0b product=%h, expected done=%0b product=%h", edges, done, product, exp_done, exp_prod);
      end
`ifdef PIPE_MULT_FULLPROD_EN
      vectors++;
      if (product_hi !== exp_hi) begin
        errors++;
        $display("FAIL random_hi: edge %0d product_hi=%h, expected %h", edges, product_hi, exp_hi);
      end
`endif
      if (edges > 60000) break;
    end
    vectors++;
    if (pulses != launches || launches != 10000) begin
      errors++;
      $display("FAIL random_count: %0d pulses for %0d launches, expected 10000 each", pulses, launches);
    end
  endtask

  initial begin
    test_reset();
    test_directed("mul_2x3", 32'd2, 32'd3, 32'h6, 32'h0);
    test_directed("wrap_ones", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 32'h2);
    test_directed("signed_neg20", 32'hFFFF_FFEC, 32'd5, 32'hFFFF_FF9C, 32'h4);
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
